// File: rtl/di_xfw_hazard_ctrl.sv
// di_xfw_hazard_ctrl: per-issue operand forwarding selects, cross-issue load scoreboard and stall/timeout FSM.
// Optional stall-cycle statistics counter built when DI_XFW_STATS_EN is defined.
module di_xfw_hazard_ctrl #(
  parameter int NREG      = 64,
  parameter int MAX_STALL = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        id_valid_i,
  input  logic        ex_ready_i,
  input  logic [5:0]  rs_a_addr_i,
  input  logic [5:0]  rs_b_addr_i,
  input  logic        rs_a_used_i,
  input  logic        rs_b_used_i,
  input  logic        loc_alu_we_fw_i,
  input  logic [5:0]  loc_alu_waddr_fw_i,
  input  logic        xfw_alu_we_fw_i,
  input  logic [5:0]  xfw_alu_waddr_fw_i,
  input  logic        xfw_we_wb_i,
  input  logic [5:0]  xfw_waddr_wb_i,
  input  logic        xfw_ld_ex_i,
  input  logic [5:0]  xfw_waddr_ex_i,
  output logic [1:0]  fw_sel_a_o,
  output logic [1:0]  fw_sel_b_o,
  output logic        stall_o,
  output logic        timeout_o,
  output logic [6:0]  pend_cnt_o,
  output logic [31:0] stall_cycles_o
);
  typedef enum logic [1:0] {IDLE, STALL, TOUT} state_t;
  state_t          state_q;
  logic [7:0]      cnt_q;
  logic            tout_q;
  logic [NREG-1:0] sb_q, sb_d;
  logic [6:0]      pend_q, pop;
  logic            haz_a, haz_b;
  function automatic logic [1:0] sel(input logic [5:0] a);
    return (a == 6'd0) ? 2'd0 :
           (loc_alu_we_fw_i && loc_alu_waddr_fw_i == a) ? 2'd1 :
           (xfw_alu_we_fw_i && xfw_alu_waddr_fw_i == a) ? 2'd2 :
           (xfw_we_wb_i && xfw_waddr_wb_i == a) ? 2'd3 : 2'd0;
  endfunction
  // a load writing back this very cycle is forwarded (sel 3), so it is not a hazard
  function automatic logic hazard(input logic used, input logic [5:0] a);
    return used && sb_q[a] && !(xfw_we_wb_i && xfw_waddr_wb_i == a);
  endfunction
  assign haz_a      = hazard(rs_a_used_i, rs_a_addr_i);
  assign haz_b      = hazard(rs_b_used_i, rs_b_addr_i);
  assign fw_sel_a_o = rst_n ? sel(rs_a_addr_i) : 2'd0;
  assign fw_sel_b_o = rst_n ? sel(rs_b_addr_i) : 2'd0;
  assign stall_o    = rst_n && id_valid_i && (haz_a || haz_b) && !flush_i;
  assign timeout_o  = tout_q;
  assign pend_cnt_o = pend_q;
  always_comb begin
    sb_d = sb_q;
    if (xfw_we_wb_i) sb_d[xfw_waddr_wb_i] = 1'b0;
    if (xfw_ld_ex_i && ex_ready_i && xfw_waddr_ex_i != 6'd0) sb_d[xfw_waddr_ex_i] = 1'b1;
    if (flush_i) sb_d = '0;
  end
  always_comb begin
    pop = '0;
    for (int i = 0; i < NREG; i++) pop = pop + 7'(sb_q[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q   <= '0;
      pend_q <= '0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pop;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (stall_o) begin
          state_q <= STALL;
          cnt_q   <= 8'd1;
        end
        STALL: if (!stall_o) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q + 8'd1 == 8'(MAX_STALL)) begin
            state_q <= TOUT;
            tout_q  <= 1'b1;
          end
        end
        default: state_q <= TOUT;
      endcase
    end
  end
`ifdef DI_XFW_STATS_EN
  logic [31:0] stats_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stats_q <= '0;
    else if (stall_o) stats_q <= stats_q + 32'd1;
  end
  assign stall_cycles_o = stats_q;
`else
  assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_di_xfw_hazard_ctrl.sv
// tb_di_xfw_hazard_ctrl: directed and randomized checks of di_xfw_hazard_ctrl against a set/run-length model.
module tb_di_xfw_hazard_ctrl;
  localparam int MAXS = 4;
  logic clk = 1'b0, rst_n;
  logic flush, idv, rdy, ua, ub, lwe, xwe, wwe, ld;
  logic [5:0] ra, rb, laddr, xaddr, waddr, ldaddr;
  logic [1:0] sel_a, sel_b;
  logic stall, tout;
  logic [6:0] pend;
  logic [31:0] stats;
  int total = 0, bad = 0;
  bit sb_m[64];
  int pend_m, run_m;
  bit tout_m;
  int unsigned stats_m;
  always #5 clk = ~clk;
  di_xfw_hazard_ctrl #(.NREG(64), .MAX_STALL(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .id_valid_i(idv), .ex_ready_i(rdy),
    .rs_a_addr_i(ra), .rs_b_addr_i(rb), .rs_a_used_i(ua), .rs_b_used_i(ub),
    .loc_alu_we_fw_i(lwe), .loc_alu_waddr_fw_i(laddr),
    .xfw_alu_we_fw_i(xwe), .xfw_alu_waddr_fw_i(xaddr),
    .xfw_we_wb_i(wwe), .xfw_waddr_wb_i(waddr),
    .xfw_ld_ex_i(ld), .xfw_waddr_ex_i(ldaddr),
    .fw_sel_a_o(sel_a), .fw_sel_b_o(sel_b), .stall_o(stall), .timeout_o(tout),
    .pend_cnt_o(pend), .stall_cycles_o(stats));
  function automatic logic [1:0] m_sel(input logic [5:0] a);
    if (a == 0) return 2'd0;
    if (lwe && laddr == a) return 2'd1;
    if (xwe && xaddr == a) return 2'd2;
    if (wwe && waddr == a) return 2'd3;
    return 2'd0;
  endfunction
  function automatic bit m_stall();
    bit ha, hb;
    ha = ua && sb_m[ra] && !(wwe && waddr == ra);
    hb = ub && sb_m[rb] && !(wwe && waddr == rb);
    return idv && !flush && (ha || hb);
  endfunction
  function automatic int unsigned m_stats();
`ifdef DI_XFW_STATS_EN
    return stats_m;
`else
    return 0;
`endif
  endfunction
  task automatic m_reset();
    foreach (sb_m[i]) sb_m[i] = 0;
    pend_m = 0; run_m = 0; tout_m = 0; stats_m = 0;
  endtask
  task automatic quiet();
    {flush, idv, rdy, ua, ub, lwe, xwe, wwe, ld} = '0;
    {ra, rb, laddr, xaddr, waddr, ldaddr} = '0;
  endtask
  // advance one clock edge, updating the model from the inputs held before the edge
  task automatic tick();
    bit s;
    int c;
    s = m_stall();
    c = 0;
    foreach (sb_m[i]) c += int'(sb_m[i]);
    pend_m = c;
    if (s) stats_m++;
    if (flush) begin
      foreach (sb_m[i]) sb_m[i] = 0;
      run_m = 0; tout_m = 0;
    end else begin
      if (wwe) sb_m[waddr] = 0;
      if (ld && rdy && ldaddr != 0) sb_m[ldaddr] = 1;
      if (!tout_m) begin
        run_m = s ? run_m + 1 : 0;
        if (run_m == MAXS) tout_m = 1;
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    quiet(); rst_n = 1'b0; m_reset();
    lwe = 1; laddr = 2; ra = 2; rb = 2;
    #12;
    total++; if ({sel_a, sel_b, stall, tout, pend} !== '0) begin bad++; $display("FAIL reset_outs got sa=%0d sb=%0d st=%0b to=%0b pc=%0d want 0", sel_a, sel_b, stall, tout, pend); end
    total++; if (stats !== 0) begin bad++; $display("FAIL reset_stats got %0d want 0", stats); end
    rst_n = 1'b1; quiet();
    @(posedge clk); #1;
    total++; if (pend !== 0 || tout !== 0) begin bad++; $display("FAIL reset_release got pc=%0d to=%0b want 0 0", pend, tout); end
  endtask
  task automatic test_load_use();
    quiet(); ld = 1; rdy = 1; ldaddr = 7;
    tick(); quiet();
    idv = 1; ua = 1; ra = 7; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got %0b want 1", stall); end
    total++; if (sel_a !== 2'd0) begin bad++; $display("FAIL lu_sel0 got %0d want 0", sel_a); end
    tick();
    total++; if (pend !== 7'd1) begin bad++; $display("FAIL lu_pend1 got %0d want 1", pend); end
    wwe = 1; waddr = 7; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_wb_stall got %0b want 0", stall); end
    total++; if (sel_a !== 2'd3) begin bad++; $display("FAIL lu_wb_sel got %0d want 3", sel_a); end
    tick(); wwe = 0; tick(); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_after_stall got %0b want 0", stall); end
    total++; if (pend !== 7'd0) begin bad++; $display("FAIL lu_pend0 got %0d want 0", pend); end
  endtask
  task automatic test_priority();
    quiet(); lwe = 1; laddr = 3; xwe = 1; xaddr = 3; wwe = 1; waddr = 3; rb = 3; ub = 1; #1;
    total++; if (sel_b !== 2'd1) begin bad++; $display("FAIL prio_loc got %0d want 1", sel_b); end
    lwe = 0; #1;
    total++; if (sel_b !== 2'd2) begin bad++; $display("FAIL prio_xalu got %0d want 2", sel_b); end
    xwe = 0; #1;
    total++; if (sel_b !== 2'd3) begin bad++; $display("FAIL prio_wb got %0d want 3", sel_b); end
    wwe = 0; lwe = 1; laddr = 4; #1;
    total++; if (sel_b !== 2'd0) begin bad++; $display("FAIL prio_nomatch got %0d want 0", sel_b); end
    quiet(); lwe = 1; xwe = 1; wwe = 1; idv = 1; ua = 1; ub = 1; ld = 1; rdy = 1; #1;
    total++; if ({sel_a, sel_b} !== 4'd0) begin bad++; $display("FAIL prio_zero got %0d/%0d want 0/0", sel_a, sel_b); end
    tick(); wwe = 0; tick(); #1;
    total++; if (pend !== 7'd0 || stall !== 1'b0) begin bad++; $display("FAIL zero_never_set got pc=%0d st=%0b want 0 0", pend, stall); end
  endtask
  task automatic test_collision();
    quiet(); ld = 1; rdy = 1; ldaddr = 9; wwe = 1; waddr = 9;
    tick(); quiet(); tick();
    idv = 1; ua = 1; ra = 9; #1;
    total++; if (pend !== 7'd1) begin bad++; $display("FAIL coll_pend got %0d want 1", pend); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL coll_stall got %0b want 1", stall); end
    quiet(); flush = 1; tick(); quiet();
  endtask
  task automatic test_timeout();
    quiet(); ld = 1; rdy = 1; ldaddr = 12; tick(); quiet();
    ua = 1; ra = 12;
    for (int k = 0; k < 6; k++) begin
      idv = (k != 2);
      tick();
      total++; if (tout !== 1'b0) begin bad++; $display("FAIL tout_interrupt k=%0d got %0b want 0", k, tout); end
    end
    idv = 0; tick(); idv = 1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL tout_stall k=%0d got %0b want 1", k, stall); end
      tick();
      total++; if (tout !== (k >= MAXS)) begin bad++; $display("FAIL tout_edge k=%0d got %0b want %0b", k, tout, k >= MAXS); end
    end
    idv = 0; tick();
    total++; if (tout !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL tout_sticky got to=%0b st=%0b want 1 0", tout, stall); end
    idv = 1; flush = 1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_gate got %0b want 0", stall); end
    tick(); flush = 0; #1;
    total++; if (tout !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL flush_clear got to=%0b st=%0b want 0 0", tout, stall); end
    tick(); quiet();
    total++; if (pend !== 7'd0) begin bad++; $display("FAIL flush_pend got %0d want 0", pend); end
  endtask
  task automatic test_stats();
    int unsigned base;
    quiet(); ld = 1; rdy = 1; ldaddr = 13; tick(); quiet();
    base = m_stats();
    idv = 1; ua = 1; ra = 13;
    repeat (10) tick();
    quiet(); flush = 1; tick(); quiet(); tick();
`ifdef DI_XFW_STATS_EN
    total++; if (stats !== base + 10) begin bad++; $display("FAIL stats_10 got %0d want %0d", stats, base + 10); end
`else
    total++; if (stats !== 32'd0) begin bad++; $display("FAIL stats_off got %0d want 0 (base %0d)", stats, base); end
`endif
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 19) == 0); idv = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 1); ld = $urandom_range(0, 1); ua = $urandom_range(0, 1); ub = $urandom_range(0, 1);
      lwe = $urandom_range(0, 1); xwe = $urandom_range(0, 1); wwe = $urandom_range(0, 2) == 0;
      ra = 6'($urandom_range(0, 7)); rb = 6'($urandom_range(0, 7)); laddr = 6'($urandom_range(0, 7));
      xaddr = 6'($urandom_range(0, 7)); waddr = 6'($urandom_range(0, 7)); ldaddr = 6'($urandom_range(0, 7));
      #1;
      total++; if (sel_a !== m_sel(ra)) begin bad++; $display("FAIL rnd_sel_a c=%0d got %0d want %0d", c, sel_a, m_sel(ra)); end
      total++; if (sel_b !== m_sel(rb)) begin bad++; $display("FAIL rnd_sel_b c=%0d got %0d want %0d", c, sel_b, m_sel(rb)); end
      total++; if (stall !== m_stall()) begin bad++; $display("FAIL rnd_stall c=%0d got %0b want %0b", c, stall, m_stall()); end
      total++; if (tout !== tout_m) begin bad++; $display("FAIL rnd_tout c=%0d got %0b want %0b", c, tout, tout_m); end
      total++; if (pend !== 7'(pend_m)) begin bad++; $display("FAIL rnd_pend c=%0d got %0d want %0d", c, pend, pend_m); end
      total++; if (stats !== m_stats()) begin bad++; $display("FAIL rnd_stats c=%0d got %0d want %0d", c, stats, m_stats()); end
      tick();
    end
    quiet();
  endtask
  task automatic test_reset_mid_stall();
    quiet(); flush = 1; tick(); quiet();
    ld = 1; rdy = 1; ldaddr = 5; tick(); quiet();
    idv = 1; ua = 1; ra = 5; lwe = 1; laddr = 6; rb = 6;
    tick(); tick(); #1;
    total++; if (stall !== 1'b1 || pend !== 7'd1) begin bad++; $display("FAIL pre_reset got st=%0b pc=%0d want 1 1", stall, pend); end
    rst_n = 1'b0; #1;
    total++; if ({sel_a, sel_b, stall, tout, pend} !== '0 || stats !== 0) begin bad++; $display("FAIL mid_reset got sa=%0d sb=%0d st=%0b to=%0b pc=%0d sc=%0d want 0", sel_a, sel_b, stall, tout, pend, stats); end
    #3 rst_n = 1'b1; m_reset();
    tick(); #1;
    total++; if (pend !== 7'd0 || stall !== 1'b0) begin bad++; $display("FAIL post_reset got pc=%0d st=%0b want 0 0", pend, stall); end
    total++; if (sel_b !== 2'd1) begin bad++; $display("FAIL post_reset_sel got %0d want 1", sel_b); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_priority();
    test_collision();
    test_timeout();
    test_stats();
    test_random();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/di_xfw_hazard_ctrl.md
Name: di_xfw_hazard_ctrl

Overview:
- Cross-issue operand hazard controller for the dual-issue core, one instance per issue, sitting in that issue's ID stage.
- Compares the issue's source register addresses against local and other-issue forwarding destinations and produces operand-mux selects.
- Keeps a scoreboard of the other issue's in-flight loads and stalls ID until each load writes back.
- Times out and flags stalls that exceed a bound.

Parameters:
- NREG, 64, number of architectural registers tracked (6-bit address space).
- MAX_STALL, 16, consecutive stall cycles before timeout_o asserts (2..255).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; clears scoreboard and FSM
- id_valid_i  in  1  ID holds a valid instruction
- ex_ready_i  in  1  other issue's EX stage accepts its instruction this cycle
- rs_a_addr_i  in  6  source A register address
- rs_b_addr_i  in  6  source B register address
- rs_a_used_i  in  1  source A is read
- rs_b_used_i  in  1  source B is read
- loc_alu_we_fw_i  in  1  local ALU forward valid
- loc_alu_waddr_fw_i  in  6  local ALU forward address
- xfw_alu_we_fw_i  in  1  other-issue ALU forward valid
- xfw_alu_waddr_fw_i  in  6  other-issue ALU forward address
- xfw_we_wb_i  in  1  other-issue WB write valid
- xfw_waddr_wb_i  in  6  other-issue WB address
- xfw_ld_ex_i  in  1  other issue has a load in EX
- xfw_waddr_ex_i  in  6  destination of that load
- fw_sel_a_o  out  2  source A mux select: 0 regfile, 1 local ALU, 2 xfw ALU, 3 xfw WB
- fw_sel_b_o  out  2  source B mux select, same encoding
- stall_o  out  1  stall ID
- timeout_o  out  1  sticky stall-timeout flag
- pend_cnt_o  out  7  number of set scoreboard bits
- stall_cycles_o  out  32  cumulative stall cycles (optional feature)

Behaviour:
- Reset (rst_n low, async):
  - scoreboard, FSM, counters and timeout_o cleared.
  - Every output is forced to 0 while rst_n is low.
- Scoreboard (NREG bits, registered):
  - Set: on xfw_ld_ex_i & ex_ready_i, set bit[xfw_waddr_ex_i]; address 0 is never set.
  - Clear: on xfw_we_wb_i, clear bit[xfw_waddr_wb_i].
  - Set and clear of the same address in one cycle: set wins.
  - flush_i clears all bits next cycle; flush has priority over set.
  - pend_cnt_o is the registered popcount, updated one cycle after the scoreboard changes.
- Forward select, combinational, per source; address 0 always selects 0. Priority:
  - local ALU match (1)
  - xfw ALU match (2)
  - xfw WB match (3)
  - otherwise regfile (0)
  - A match requires the corresponding we bit.
- Hazard, per source: used & bit[addr] set & not (xfw_we_wb_i & xfw_waddr_wb_i==addr).
  - A same-cycle WB is forwarded with sel 3 and does not stall.
- stall_o = id_valid_i & (hazard_a | hazard_b) & ~flush_i. Zero latency from the scoreboard registers.
- FSM states:
  - IDLE: stall_o=1 → STALL, counter=1.
  - STALL: stall_o=1 → increment counter; stall_o=0 → IDLE, counter=0. When the counter reaches MAX_STALL, set timeout_o and go to TOUT.
  - TOUT: stall_o still driven; timeout_o held high. Leaves to IDLE only on flush_i.
  - flush_i in any state → IDLE, counter=0, timeout_o=0 next cycle.
- Counter saturates at MAX_STALL. A stall with id_valid_i dropping mid-sequence returns to IDLE.

Optional Feature:
- Macro DI_XFW_STATS_EN.
- Defined:
  - 32-bit register increments every cycle stall_o=1 and wraps at 2^32-1 → 0.
  - Not cleared by flush, only by reset.
  - Drives stall_cycles_o.
- Undefined: no register is built; stall_cycles_o is tied to 0.

Test Plan:
- Reset mid-stall: scoreboard bit 5 set, stall active, rst_n pulse low → all outputs 0 immediately; pend_cnt_o=0 after release.
- Load-use: xfw_ld_ex_i=1, xfw_waddr_ex_i=7, ex_ready_i=1; next cycle rs_a_addr_i=7 used → stall_o=1. Then xfw_we_wb_i=1 with addr 7 → stall_o=0, fw_sel_a_o=3 that cycle, pend_cnt_o returns 0.
- Priority: loc_alu and xfw_alu both write addr 3, rs_b_addr_i=3 → fw_sel_b_o=1. Addr 0 with all forwards targeting 0 → sel 0, no stall.
- Set/clear collision: same cycle load to 9 in EX and WB to 9 → bit 9 remains set, pend_cnt_o=1.
- Timeout: MAX_STALL=4, hold hazard 4 cycles → timeout_o=1 on the 4th stall cycle and stays high. flush_i → timeout_o=0, scoreboard empty, stall_o=0.
- With DI_XFW_STATS_EN: 10 stall cycles followed by a flush → stall_cycles_o=10 (not cleared). Without the macro: stall_cycles_o=0.
